// File: rtl/cache_ctrl_if.sv
// Single-outstanding word bus used on both sides of the cache controller:
// the CPU drives it as master toward the controller, the controller drives it toward memory.
interface cache_ctrl_if;
  logic [31:0] a;
  logic [31:0] d;
  logic        we;
  logic        rd;
  logic [31:0] spo;
  logic        ready;

  modport master (output a, d, we, rd, input spo, ready);
  modport slave  (input a, d, we, rd, output spo, ready);
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back cache controller driving one cacheway (data BRAM + tag RAM).
// Blocking: one CPU request and at most one memory transfer in flight.
module cache_ctrl #(
  parameter int LINES           = 128,
  parameter int WORDS_PER_BLOCK = 32,
  parameter int TAG_LENGTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_ctrl_if.slave           cpu,
  cache_ctrl_if.master          mem,
  output logic                  way_en,
  output logic [31:0]           way_a,
  output logic [31:0]           way_d,
  output logic                  way_we,
  input  logic [31:0]           way_spo,
  output logic                  way_tag_we,
  output logic [TAG_LENGTH-1:0] way_tag_in,
  input  logic [TAG_LENGTH-1:0] way_tag_out,
  input  logic                  way_init_done,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);
  localparam int OW = $clog2(WORDS_PER_BLOCK);
  localparam int IW = $clog2(LINES);
  localparam int AW = 32 - IW - OW - 2;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOOKUP, S_RD_WAIT, S_WB_RD, S_WB_WR, S_FILL, S_FILL_TAG
  } state_t;

  state_t state, next;

  logic [31:0]   addr_q, d_q, spo_q;
  logic          wr_q, refill, ready_q;
  logic [OW-1:0] cnt;
  logic [AW-1:0] old_tag, tag_q;
  logic [IW-1:0] idx_q;
  logic          valid, dirty, hit, last;
  logic          set_ready, load_spo, count_hit, count_miss, advance;
  logic          unused_bits;

  assign tag_q  = addr_q[31 -: AW];
  assign idx_q  = addr_q[OW+2 +: IW];
  assign valid  = way_tag_out[TAG_LENGTH-1];
  assign dirty  = way_tag_out[TAG_LENGTH-2];
  assign hit    = valid && (way_tag_out[AW-1:0] == tag_q);
  assign last   = &cnt;
  assign way_en = (state != S_INIT);
  assign cpu.ready = ready_q;
  assign cpu.spo   = spo_q;
  assign unused_bits = ^{way_tag_out[TAG_LENGTH-3:AW], addr_q[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= next;
  end

  always_comb begin
    next       = state;
    way_a      = addr_q;
    way_d      = d_q;
    way_we     = 1'b0;
    way_tag_we = 1'b0;
    way_tag_in = '0;
    mem.a      = {tag_q, idx_q, cnt, 2'b00};
    mem.d      = way_spo;
    mem.we     = 1'b0;
    mem.rd     = 1'b0;
    set_ready  = 1'b0;
    load_spo   = 1'b0;
    count_hit  = 1'b0;
    count_miss = 1'b0;
    advance    = 1'b0;
    case (state)
      S_INIT:    if (way_init_done) next = S_IDLE;
      // ready still high means the CPU has not yet seen completion of the last request
      S_IDLE:    if ((cpu.rd || cpu.we) && !ready_q) next = S_LOOKUP;
      S_LOOKUP: begin
        if (hit) begin
          count_hit = !refill;
          if (wr_q) begin
            way_we                     = 1'b1;
            way_tag_we                 = 1'b1;
            way_tag_in[TAG_LENGTH-1]   = 1'b1;
            way_tag_in[TAG_LENGTH-2]   = 1'b1;
            way_tag_in[AW-1:0]         = tag_q;
            set_ready                  = 1'b1;
            next                       = S_IDLE;
          end else begin
            next = S_RD_WAIT;
          end
        end else begin
          // Invalidate up front so an aborted fill never leaves a valid tag on partial data.
          count_miss = 1'b1;
          way_tag_we = 1'b1;
          next       = (valid && dirty) ? S_WB_RD : S_FILL;
        end
      end
      S_RD_WAIT: begin
        load_spo  = 1'b1;
        set_ready = 1'b1;
        next      = S_IDLE;
      end
      S_WB_RD: begin
        way_a = {old_tag, idx_q, cnt, 2'b00};
        next  = S_WB_WR;
      end
      S_WB_WR: begin
        way_a  = {old_tag, idx_q, cnt, 2'b00};
        mem.a  = {old_tag, idx_q, cnt, 2'b00};
        mem.we = 1'b1;
        if (mem.ready) begin
          advance = 1'b1;
          next    = last ? S_FILL : S_WB_RD;
        end
      end
      S_FILL: begin
        way_a  = {tag_q, idx_q, cnt, 2'b00};
        mem.rd = 1'b1;
        if (mem.ready) begin
          way_we  = 1'b1;
          way_d   = mem.spo;
          advance = 1'b1;
          if (last) next = S_FILL_TAG;
        end
      end
      S_FILL_TAG: begin
        way_tag_we               = 1'b1;
        way_tag_in[TAG_LENGTH-1] = 1'b1;
        way_tag_in[AW-1:0]       = tag_q;
        next                     = S_LOOKUP;
      end
      default: next = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      d_q      <= '0;
      wr_q     <= 1'b0;
      refill   <= 1'b0;
      cnt      <= '0;
      old_tag  <= '0;
      ready_q  <= 1'b0;
      spo_q    <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      ready_q <= set_ready;
      if (load_spo) spo_q <= way_spo;
      if (state == S_IDLE && next == S_LOOKUP) begin
        addr_q <= cpu.a;
        d_q    <= cpu.d;
        wr_q   <= cpu.we;
        refill <= 1'b0;
      end
      if (state == S_FILL_TAG) refill <= 1'b1;
      if (state == S_LOOKUP) old_tag <= way_tag_out[AW-1:0];
      if (advance) cnt <= cnt + 1'b1;
      if (count_hit && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      if (count_miss && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
    end
  end
endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
Direct-mapped cache controller that sits between the CPU-side bus and one cacheway instance (data BRAM plus tag RAM).
- Performs the tag compare and hit/miss decision.
- Does write-back of dirty lines and line fill from the memory-side bus.
- Sequences the cacheway's address, data, we, tag_we and tag_in ports.
- One outstanding request on each side; blocking, no prefetch.

Parameters:
- LINES, 128: lines in the way; must match cacheway.
- WORDS_PER_BLOCK, 32: 32-bit words per line; must match cacheway.
- TAG_LENGTH, 32: width of the cacheway tag word.
  - bit TAG_LENGTH-1 = valid; bit TAG_LENGTH-2 = dirty.
  - Low AW bits = address tag, where AW = 32 - log2(LINES) - log2(WORDS_PER_BLOCK) - 2 (18 with defaults).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- a  in  32  CPU word address; bits [1:0] ignored
- d  in  32  CPU write data
- we  in  1  CPU write request
- rd  in  1  CPU read request
- spo  out  32  CPU read data, valid while ready=1
- ready  out  1  one-cycle completion pulse
- way_en  out  1  cacheway en
- way_a  out  32  cacheway address
- way_d  out  32  cacheway write data
- way_we  out  1  cacheway data write
- way_spo  in  32  cacheway read data, one-cycle synchronous read
- way_tag_we  out  1  cacheway tag write
- way_tag_in  out  TAG_LENGTH  tag word to write
- way_tag_out  in  TAG_LENGTH  tag word at way_a index, combinational
- way_init_done  in  1  cacheway tag clear finished
- mem_a  out  32  memory word address
- mem_d  out  32  memory write data
- mem_we  out  1  memory write request
- mem_rd  out  1  memory read request
- mem_spo  in  32  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion pulse
- hit_cnt  out  32  read+write hit counter, saturating
- miss_cnt  out  32  miss counter, saturating

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to INIT.
  - ready, way_we, way_tag_we, mem_we, mem_rd, way_en all 0; spo 0; counters 0.
  - Any in-flight memory transaction is abandoned.
  - A mid-fill line is not marked valid, so no stale tag is left valid.
- CPU handshake:
  - rd or we is sampled in IDLE only. a, d, rd, we are held stable by the CPU until ready.
  - rd and we both set is treated as a write.
  - A new request is accepted no earlier than the cycle after ready.
- INIT: wait for way_init_done=1, then go to IDLE. Requests during INIT wait.
- IDLE → LOOKUP on request.
  - Latch a and d.
  - Address fields: offset = a[log2(WPB)+1:2]; index = next log2(LINES) bits; tag = remaining upper bits.
- LOOKUP: hit = valid & (stored tag == addr tag).
  - Read hit: RD_WAIT for one cycle, then ready=1 with spo=way_spo. ready is 3 cycles after the request is sampled.
  - Write hit:
    - way_we=1 and way_tag_we=1 with tag_in = {valid=1, dirty=1, tag}.
    - ready=1 the next cycle.
  - hit_cnt increments on any hit.
  - Miss: miss_cnt increments.
    - If valid & dirty → WB; otherwise → FILL.
- WB: for word i = 0..WPB-1:
  - Drive way_a = {old tag, index, i, 00}; wait 1 cycle.
  - Then mem_we=1 with mem_a = same address and mem_d = way_spo.
  - Hold until mem_ready, then i+1.
  - After the last word → FILL.
- FILL: for word i = 0..WPB-1:
  - mem_rd=1 with mem_a = {new tag, index, i, 00}; hold until mem_ready.
  - On mem_ready: way_we=1 with way_d = mem_spo at the same offset.
  - After the last word: way_tag_we=1 with tag_in = {1, 0, new tag}, then go back to LOOKUP (guaranteed hit).
- mem_rd and mem_we are never both high. Each stays high continuously until its mem_ready.
- Word counters are log2(WPB) bits and wrap to 0 after the last word.
- Counters saturate at 0xFFFFFFFF.
- way_en is high in every state except INIT.

Test Plan:
- Reset, wait way_init_done; read 0x00001000 → miss_cnt=1.
  - 32 mem reads at 0x00001000..0x0000107C in order, then ready with spo=mem[0x1000].
  - Tag at index 0x20 = valid, clean, tag 0x00000.
- Read 0x00001004 → hit, ready exactly 3 cycles after the request, no mem_rd/mem_we, hit_cnt=1.
- Write 0x00001008 with 0xDEADBEEF → hit, line marked dirty.
  - Then read 0x00005008 (same index 0x20, tag 0x1) → 32 mem writes to 0x1000..0x107C with 0xDEADBEEF at 0x1008.
  - Then 32 mem reads from 0x5000; ready with mem[0x5008].
- Assert rst during the 10th fill word → ready, mem_rd, way_we drop the same cycle.
  - After release, INIT is held until way_init_done.
  - Then read 0x00001000 misses again.
- Assert rd during INIT → no ready and no memory traffic until way_init_done rises; then a normal miss sequence.
- mem_ready delayed 7 cycles per word → mem_a and mem_rd stay stable for the whole wait; total fill still 32 transfers.
